// File: rtl/m68k_bus_master.sv
// ---------------------------------------------------------------------------
// m68k_bus_master
//   Host-side master for an asynchronous MC68000-style 16-bit bus.
//   The host gives a single-word request (req/we/addr/be/fc_in/wdata).
//   The block then runs one bus cycle (ADDR -> STRB -> WAIT -> TERM) and
//   ends it with a one-cycle ack (normal end) or err (bus error) pulse.
//
//   Ports
//     clk, reset_n          clock, asynchronous active-low reset
//     req, we, addr, be,    host request; sampled only while idle
//     fc_in, wdata
//     rdata, busy, ack, err host response; rdata is valid while ack = 1
//     as_n, uds_n, lds_n,   bus strobes, direction, function code, address
//     rw, fc, a_out
//     d_out, d_oe, d_in     bus data out / output enable / data in
//     dtack_n, berr_n       asynchronous bus terminations (synchronized here)
//
//   Optional feature: define BUS_TIMEOUT_EN to bound the WAIT state.
//   After TIMEOUT_CYCLES WAIT clocks with no dtack/berr, the cycle ends
//   with err. Without the macro, WAIT lasts until the bus responds.
// ---------------------------------------------------------------------------
module m68k_bus_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [22:0] addr,
  input  logic [1:0]  be,
  input  logic [2:0]  fc_in,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic        as_n,
  output logic        uds_n,
  output logic        lds_n,
  output logic        rw,
  output logic [2:0]  fc,
  output logic [22:0] a_out,
  output logic [15:0] d_out,
  output logic        d_oe,
  input  logic [15:0] d_in,
  input  logic        dtack_n,
  input  logic        berr_n
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_WAIT,
    ST_TERM
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        as_n_q, as_n_d;
  logic        uds_n_q, uds_n_d;
  logic        lds_n_q, lds_n_d;
  logic        rw_q, rw_d;
  logic [2:0]  fc_q, fc_d;
  logic [22:0] a_out_q, a_out_d;
  logic [15:0] d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  // Two-flop synchronizers for the asynchronous bus terminations
  logic        dtack_s1_q, dtack_s1_d, dtack_s2_q, dtack_s2_d;
  logic        berr_s1_q, berr_s1_d, berr_s2_q, berr_s2_d;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    as_n_d     = as_n_q;
    uds_n_d    = uds_n_q;
    lds_n_d    = lds_n_q;
    rw_d       = rw_q;
    fc_d       = fc_q;
    a_out_d    = a_out_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    dtack_s1_d = dtack_n;
    dtack_s2_d = dtack_s1_q;
    berr_s1_d  = berr_n;
    berr_s2_d  = berr_s1_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    // All outputs are computed for the next state, so the registered
    // values always match the state the FSM is in.
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (be != 2'b00) begin
            state_d = ST_ADDR;
            we_d    = we;
            be_d    = be;
            wdata_d = wdata;
            a_out_d = addr;
            fc_d    = fc_in;
            rw_d    = ~we;
            busy_d  = 1'b1;
          end else begin
            // No lane enabled: reject at once, never touch the bus
            err_d = 1'b1;
          end
        end
      end

      ST_ADDR: begin
        state_d = ST_STRB;
        as_n_d  = 1'b0;
        if (!we_q) begin
          // Reads assert data strobes together with address strobe
          uds_n_d = ~be_q[1];
          lds_n_d = ~be_q[0];
        end else begin
          d_out_d = wdata_q;
          d_oe_d  = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        cnt_d = '0;
`endif
      end

      ST_STRB: begin
        state_d = ST_WAIT;
        if (we_q) begin
          // Writes assert data strobes one clock after address strobe,
          // once the data on the bus is stable
          uds_n_d = ~be_q[1];
          lds_n_d = ~be_q[0];
        end
      end

      ST_WAIT: begin
        // berr wins over dtack when both arrive together
        if (!berr_s2_q || !dtack_s2_q) begin
          state_d = ST_TERM;
          ack_d   = berr_s2_q;
          err_d   = ~berr_s2_q;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_TERM;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (state_d == ST_TERM) begin
          as_n_d  = 1'b1;
          uds_n_d = 1'b1;
          lds_n_d = 1'b1;
          d_oe_d  = 1'b0;
          if (!we_q) begin
            rdata_d = d_in;
          end
        end
      end

      ST_TERM: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rw_d    = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        as_n_d  = 1'b1;
        uds_n_d = 1'b1;
        lds_n_d = 1'b1;
        d_oe_d  = 1'b0;
        rw_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      be_q       <= 2'b00;
      wdata_q    <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      as_n_q     <= 1'b1;
      uds_n_q    <= 1'b1;
      lds_n_q    <= 1'b1;
      rw_q       <= 1'b1;
      fc_q       <= '0;
      a_out_q    <= '0;
      d_out_q    <= '0;
      d_oe_q     <= 1'b0;
      dtack_s1_q <= 1'b1;
      dtack_s2_q <= 1'b1;
      berr_s1_q  <= 1'b1;
      berr_s2_q  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      as_n_q     <= as_n_d;
      uds_n_q    <= uds_n_d;
      lds_n_q    <= lds_n_d;
      rw_q       <= rw_d;
      fc_q       <= fc_d;
      a_out_q    <= a_out_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      dtack_s1_q <= dtack_s1_d;
      dtack_s2_q <= dtack_s2_d;
      berr_s1_q  <= berr_s1_d;
      berr_s2_q  <= berr_s2_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign as_n  = as_n_q;
  assign uds_n = uds_n_q;
  assign lds_n = lds_n_q;
  assign rw    = rw_q;
  assign fc    = fc_q;
  assign a_out = a_out_q;
  assign d_out = d_out_q;
  assign d_oe  = d_oe_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// ---------------------------------------------------------------------------
// tb_m68k_bus_master
//   Directed bench for m68k_bus_master. All activity (input drive and
//   output sampling) happens 1 ns after the rising clock edge.
//   Cycle index 1 is the first sample after the request is accepted.
//   A dtack/berr driven at sample n therefore shows up in TERM at n+3:
//   two synchronizer stages plus one FSM register.
// ---------------------------------------------------------------------------
module tb_m68k_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [22:0] addr;
  logic [1:0]  be;
  logic [2:0]  fc_in;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy, ack, err;
  logic        as_n, uds_n, lds_n, rw;
  logic [2:0]  fc;
  logic [22:0] a_out;
  logic [15:0] d_out;
  logic        d_oe;
  logic [15:0] d_in;
  logic        dtack_n, berr_n;

  int n_cmp = 0;
  int n_mis = 0;

  // Observations recorded by do_cycle
  int          n_ack, n_err, term_cyc, as_fall, uds_fall, lds_fall;
  int          rw_bad, addr_bad, doe_bad;
  logic [15:0] rdata_t;
  logic [2:0]  strobe_t;
  logic        doe_t, busy_after, as_c1;
  logic [2:0]  fc_c1;

  always #5 clk = ~clk;

  m68k_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .be      (be),
    .fc_in   (fc_in),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .ack     (ack),
    .err     (err),
    .as_n    (as_n),
    .uds_n   (uds_n),
    .lds_n   (lds_n),
    .rw      (rw),
    .fc      (fc),
    .a_out   (a_out),
    .d_out   (d_out),
    .d_oe    (d_oe),
    .d_in    (d_in),
    .dtack_n (dtack_n),
    .berr_n  (berr_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One host transaction. dly < 0: termination held low before the request;
  // dly >= 0: termination driven dly samples after as_n falls;
  // both = 1: berr_n driven together with dtack_n.
  task automatic do_cycle(input logic w, input logic [22:0] a, input logic [1:0] b,
                          input logic [15:0] wd, input logic [15:0] di,
                          input int dly, input logic both, input int max_cyc);
    n_ack = 0; n_err = 0; term_cyc = -1; as_fall = -1; uds_fall = -1; lds_fall = -1;
    rw_bad = 0; addr_bad = 0; doe_bad = 0; busy_after = 1'b1;
    rdata_t = '0; strobe_t = '0; doe_t = 1'b1; as_c1 = 1'b0; fc_c1 = '0;
    d_in = di;
    if (dly < 0) begin
      dtack_n = 1'b0;
      berr_n  = both ? 1'b0 : 1'b1;
    end
    req = 1'b1; we = w; addr = a; be = b; wdata = wd; fc_in = 3'b110;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (cyc == 1) begin
        as_c1 = as_n;
        fc_c1 = fc;
      end
      if (!as_n && as_fall < 0) as_fall = cyc;
      if (!uds_n && uds_fall < 0) uds_fall = cyc;
      if (!lds_n && lds_fall < 0) lds_fall = cyc;
      if (busy && rw !== !w) rw_bad++;
      if (busy && a_out !== a) addr_bad++;
      if (ack) n_ack++;
      if (err) n_err++;
      if ((ack || err) && term_cyc < 0) begin
        term_cyc = cyc;
        rdata_t  = rdata;
        strobe_t = {as_n, uds_n, lds_n};
        doe_t    = d_oe;
      end else if (term_cyc < 0 && as_fall > 0 && w && (d_oe !== 1'b1 || d_out !== wd)) begin
        doe_bad++;
      end
      if (term_cyc > 0 && cyc == term_cyc + 1) busy_after = busy;
      if (dly >= 0 && as_fall > 0 && cyc == as_fall + dly) begin
        dtack_n = 1'b0;
        if (both) berr_n = 1'b0;
      end
      if (term_cyc > 0 && cyc == term_cyc + 2) break;
    end
    dtack_n = 1'b1;
    berr_n  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b, cnt_c;
    reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; fc_in = '0;
    wdata = '0; d_in = '0; dtack_n = 1'b1; berr_n = 1'b1;
    #12;
    // Reset state
    chk("rst_strobes", {as_n, uds_n, lds_n}, 3'b111);
    chk("rst_rw", rw, 1'b1);
    chk("rst_doe", d_oe, 1'b0);
    chk("rst_busy_ack_err", {busy, ack, err}, 3'b000);
    chk("rst_fc", fc, 3'd0);
    chk("rst_a_out", a_out, 23'd0);
    chk("rst_d_out", d_out, 16'd0);
    chk("rst_rdata", rdata, 16'd0);
    @(posedge clk); #4; reset_n = 1'b1;
    idle(2);

    // Word read, dtack 3 samples after as_n falls
    do_cycle(1'b0, 23'h700000, 2'b11, 16'h0000, 16'hBEEF, 3, 1'b0, 40);
    chk("rd_as_c1", as_c1, 1'b1);
    chk("rd_fc_c1", fc_c1, 3'b110);
    chk("rd_as_fall", as_fall, 2);
    chk("rd_uds_fall", uds_fall, 2);
    chk("rd_lds_fall", lds_fall, 2);
    chk("rd_term_cyc", term_cyc, 8);
    chk("rd_ack_cnt", n_ack, 1);
    chk("rd_err_cnt", n_err, 0);
    chk("rd_rdata", rdata_t, 16'hBEEF);
    chk("rd_rw_bad", rw_bad, 0);
    chk("rd_addr_bad", addr_bad, 0);
    chk("rd_term_strobes", strobe_t, 3'b111);
    chk("rd_busy_after", busy_after, 1'b0);
    idle(2);

    // Lower-byte write
    do_cycle(1'b1, 23'h012345, 2'b01, 16'h1234, 16'h0000, 2, 1'b0, 40);
    chk("wr_as_fall", as_fall, 2);
    chk("wr_lds_fall", lds_fall, 3);
    chk("wr_uds_fall", uds_fall, -1);
    chk("wr_doe_bad", doe_bad, 0);
    chk("wr_doe_term", doe_t, 1'b0);
    chk("wr_term_cyc", term_cyc, 7);
    chk("wr_ack_cnt", n_ack, 1);
    chk("wr_err_cnt", n_err, 0);
    chk("wr_rw_bad", rw_bad, 0);
    idle(2);

    // Upper-byte read: rdata carries the whole bus word
    do_cycle(1'b0, 23'h000010, 2'b10, 16'h0000, 16'hA55A, 0, 1'b0, 40);
    chk("rdb_uds_fall", uds_fall, 2);
    chk("rdb_lds_fall", lds_fall, -1);
    chk("rdb_rdata", rdata_t, 16'hA55A);
    chk("rdb_term_cyc", term_cyc, 5);
    idle(2);

    // dtack and berr together: berr wins
    do_cycle(1'b0, 23'h000020, 2'b11, 16'h0000, 16'h1111, 1, 1'b1, 40);
    chk("both_err_cnt", n_err, 1);
    chk("both_ack_cnt", n_ack, 0);
    chk("both_term_strobes", strobe_t, 3'b111);
    chk("both_term_cyc", term_cyc, 6);
    idle(3);

    // Minimum-length cycle: dtack already low when the request arrives
    do_cycle(1'b0, 23'h000030, 2'b11, 16'h0000, 16'h5A5A, -1, 1'b0, 40);
    chk("min_term_cyc", term_cyc, 4);
    chk("min_ack_cnt", n_ack, 1);
    chk("min_rdata", rdata_t, 16'h5A5A);
    idle(3);

    // Request with no byte lanes
    req = 1'b1; we = 1'b0; addr = 23'h000040; be = 2'b00;
    @(posedge clk); #1;
    req = 1'b0;
    chk("be0_err", err, 1'b1);
    chk("be0_busy_ack", {busy, ack}, 2'b00);
    cnt_a = (as_n == 1'b0) ? 1 : 0;
    @(posedge clk); #1;
    chk("be0_err_end", err, 1'b0);
    if (!as_n) cnt_a++;
    idle(0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (!as_n) cnt_a++;
    end
    chk("be0_as_low", cnt_a, 0);
    idle(1);

    // Reset during WAIT of a write
    req = 1'b1; we = 1'b1; addr = 23'h0ABCDE; be = 2'b11; wdata = 16'hCAFE; fc_in = 3'b001;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstw_pre_as", as_n, 1'b0);
    chk("rstw_pre_doe", d_oe, 1'b1);
    chk("rstw_pre_strobes", {uds_n, lds_n}, 2'b00);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_strobes", {as_n, uds_n, lds_n}, 3'b111);
    chk("rstw_doe", d_oe, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_rw", rw, 1'b1);
    @(posedge clk); #4; reset_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack || err) cnt_a++;
      if (!as_n || busy) cnt_b++;
    end
    chk("rstw_no_term", cnt_a, 0);
    chk("rstw_idle", cnt_b, 0);
    do_cycle(1'b0, 23'h000050, 2'b11, 16'h0000, 16'h7E57, 0, 1'b0, 40);
    chk("rstw_next_ack", n_ack, 1);
    chk("rstw_next_rdata", rdata_t, 16'h7E57);
    chk("rstw_next_term", term_cyc, 5);
    idle(2);

`ifdef BUS_TIMEOUT_EN
    // No response: timeout after 8 WAIT cycles (samples 3..10), TERM at 11
    do_cycle(1'b0, 23'h000060, 2'b11, 16'h0000, 16'h0000, 1000, 1'b0, 40);
    chk("to_term_cyc", term_cyc, 11);
    chk("to_err_cnt", n_err, 1);
    chk("to_ack_cnt", n_ack, 0);
`else
    // No response and no timeout: the cycle never ends
    req = 1'b1; we = 1'b0; addr = 23'h000060; be = 2'b11;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (!busy) cnt_a++;
      if (ack || err) cnt_b++;
      if (i >= 2 && as_n) cnt_c++;
    end
    chk("unb_busy_drop", cnt_a, 0);
    chk("unb_term", cnt_b, 0);
    chk("unb_as_high", cnt_c, 0);
    reset_n = 1'b0;
    @(posedge clk); #4; reset_n = 1'b1;
    idle(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/m68k_bus_master.md
M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, which sets the WAIT-state clock count before forced bus error (used only with the Configuration macro).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 1 bit: host request, sampled only in IDLE.
REQ-005 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-006 The block SHALL have port addr, input, 23 bits: word address A23..A1.
REQ-007 The block SHALL have port be, input, 2 bits: byte enables; bit1 = upper (D15..8), bit0 = lower (D7..0).
REQ-008 The block SHALL have port fc_in, input, 3 bits: function code for the cycle.
REQ-009 The block SHALL have port wdata, input, 16 bits: write data.
REQ-010 The block SHALL have port rdata, output, 16 bits: read data, valid while ack = 1.
REQ-011 The block SHALL have ports busy, ack and err, each output, 1 bit: cycle in progress, normal termination pulse, and error termination pulse respectively.
REQ-012 The block SHALL have bus outputs as_n, uds_n and lds_n (1 bit each), rw (1 bit), fc (3 bits), a_out (23 bits), d_out (16 bits) and d_oe (1 bit).
REQ-013 The block SHALL have bus inputs d_in (16 bits), and dtack_n and berr_n (1 bit each, asynchronous to clk).

Function
REQ-014 dtack_n and berr_n SHALL each pass through a two-flop synchronizer before use.
REQ-015 The block SHALL implement states IDLE, ADDR, STRB, WAIT and TERM.
REQ-016 In IDLE with req = 1 and be != 0, the block SHALL capture we/addr/be/fc_in/wdata and enter ADDR; busy SHALL be 1 from the next cycle through TERM inclusive.
REQ-017 In IDLE with req = 1 and be = 0, the block SHALL pulse err for exactly one cycle and start no bus cycle.
REQ-018 In ADDR, a_out, fc and rw (= ~we) SHALL be driven, with as_n, uds_n and lds_n still high; the next state SHALL be STRB.
REQ-019 In STRB, as_n SHALL go low; for a read, uds_n/lds_n SHALL go low per be in the same cycle; for a write, d_out = wdata and d_oe = 1; the next state SHALL be WAIT.
REQ-020 In WAIT on a write, uds_n/lds_n SHALL be low per be; the block SHALL stay in WAIT until synchronized dtack_n = 0 or berr_n = 0.
REQ-021 When synchronized berr_n = 0 and dtack_n = 0 in the same cycle, the block SHALL treat it as an error (berr_n has priority).
REQ-022 On exit from WAIT to TERM, the block SHALL negate as_n, uds_n and lds_n, drop d_oe, latch d_in into rdata (reads only), and assert ack or err for exactly one TERM cycle; the next state SHALL be IDLE.
REQ-023 On a byte read, rdata SHALL hold the full d_in; only lanes enabled by be are meaningful.
REQ-024 ack and err SHALL never be 1 in the same cycle; req SHALL be ignored in all states except IDLE.
REQ-025 Minimum cycle length SHALL be ADDR, STRB, WAIT(1), TERM: 4 clocks from acceptance to ack.

Reset
REQ-026 While reset_n = 0, the block SHALL immediately set state = IDLE, as_n = uds_n = lds_n = 1, rw = 1, d_oe = 0, busy = ack = err = 0, fc = 0, a_out = 0, d_out = 0, rdata = 0, synchronizers = 1 and timeout count = 0.
REQ-027 Reset asserted mid-cycle SHALL abort the cycle with no ack/err pulse; after release, the block SHALL start in IDLE.

Configuration
REQ-028 With BUS_TIMEOUT_EN defined, a counter SHALL clear on STRB entry and increment each WAIT cycle; on reaching TERMINATE condition count = TIMEOUT_CYCLES - 1 without dtack/berr, the block SHALL go to TERM with err = 1.
REQ-029 Without BUS_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL be unbounded.

Verification
REQ-030 Read, be = 11, addr = 0x700000, dtack_n low 3 cycles after as_n falls, d_in = 0xBEEF -> ack single pulse, rdata = 0xBEEF, rw = 1 throughout, err = 0.
REQ-031 Write, be = 01, wdata = 0x1234 -> as_n falls one cycle before lds_n, uds_n stays 1, d_oe = 1 until TERM, ack pulse.
REQ-032 dtack_n and berr_n asserted together -> err pulse, ack = 0, strobes negated in TERM.
REQ-033 req with be = 00 -> err pulse next cycle, as_n never low.
REQ-034 reset_n pulsed low during WAIT -> as_n/uds_n/lds_n = 1 and d_oe = 0 immediately, no ack/err pulse, next request completes normally.
REQ-035 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, dtack_n held high -> err pulse after 8 WAIT cycles; without the macro, busy stays 1 for 1000 cycles.
